// File: rtl/lsu_pkg.sv
// Load/store unit shared types and constants.
// funct3 encodings, FSM states, address/lane widths.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int EA_W = 32;
  localparam int BE_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WB_SETUP,
    WB,
    FIN
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store lanes/enables, load extraction,
// and illegal/misaligned detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      lo,
  input  logic [EA_W-1:0] sdata,
  input  logic [EA_W-1:0] rdata,
  output logic [BE_W-1:0] be,
  output logic [EA_W-1:0] wdata,
  output logic [EA_W-1:0] ldata,
  output logic            bad
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        ill;
  logic        mis;

  always_comb begin
    b     = 8'(rdata >> {lo, 3'b000});
    h     = 16'(rdata >> {lo[1], 4'b0000});
    be    = '0;
    wdata = sdata;
    ldata = rdata;
    ill   = 1'b0;
    mis   = 1'b0;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << lo;
        wdata = {4{sdata[7:0]}};
        ldata = {{24{b[7]}}, b};
      end
      F3_H: begin
        be    = 4'b0011 << lo;
        wdata = {2{sdata[15:0]}};
        ldata = {{16{h[15]}}, h};
        mis   = lo[0];
      end
      F3_W: begin
        be  = 4'b1111;
        mis = |lo;
      end
      // unsigned variants exist only for loads
      F3_BU: begin
        be    = 4'b0001 << lo;
        ldata = {24'b0, b};
        ill   = is_store;
      end
      F3_HU: begin
        be    = 4'b0011 << lo;
        ldata = {16'b0, h};
        mis   = lo[0];
        ill   = is_store;
      end
      default: ill = 1'b1;
    endcase
    bad = ill | mis;
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one aligned access over a
// req/ack bus, load write-back with a setup cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] store_data,
  input  logic [AW-1:0]    rd,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             rf_we,
  output logic [AW-1:0]    rf_addr,
  output logic [WIDTH-1:0] rf_data
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;

  logic          st_q;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q;
  logic [AW-1:0] rd_q;

  logic [WIDTH-1:0] ea;
  logic             idle;
  logic             a_st;
  logic [2:0]       a_f3;
  logic [1:0]       a_lo;
  logic [3:0]       a_be;
  logic [WIDTH-1:0] a_wdata;
  logic [WIDTH-1:0] a_ldata;
  logic             a_bad;

  logic accept;
  logic latch_rf;
  logic req_d;
  logic fault_d;

  assign ea   = base + offset;
  assign idle = (state == IDLE);
  // IDLE decodes the incoming op, REQ the latched one
  assign a_st = idle ? is_store : st_q;
  assign a_f3 = idle ? funct3 : f3_q;
  assign a_lo = idle ? ea[1:0] : lo_q;

  lsu_align u_align (
    .is_store (a_st),
    .funct3   (a_f3),
    .lo       (a_lo),
    .sdata    (store_data),
    .rdata    (mem_rdata),
    .be       (a_be),
    .wdata    (a_wdata),
    .ldata    (a_ldata),
    .bad      (a_bad)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    accept   = 1'b0;
    latch_rf = 1'b0;
    req_d    = 1'b0;
    fault_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (a_bad) begin
            state_d = FIN;
            fault_d = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (st_q) begin
            state_d = FIN;
          end else begin
            state_d  = WB_SETUP;
            latch_rf = 1'b1;
          end
        end else if (TIMEOUT != 0 && cnt == TMAX) begin
          state_d = FIN;
          fault_d = 1'b1;
        end else begin
          req_d = 1'b1;
          if (TIMEOUT != 0) cnt_d = cnt + CW'(1);
        end
      end
      WB_SETUP: state_d = WB;
      WB:       state_d = IDLE;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      st_q      <= 1'b0;
      f3_q      <= '0;
      lo_q      <= '0;
      rd_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_data   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == FIN) || (state_d == WB);
      fault   <= fault_d;
      mem_req <= req_d;
      mem_we  <= req_d & a_st;
      rf_we   <= (state == WB_SETUP) && (rf_addr != '0);
      if (accept) begin
        st_q      <= is_store;
        f3_q      <= funct3;
        lo_q      <= ea[1:0];
        rd_q      <= rd;
        mem_addr  <= {ea[WIDTH-1:2], 2'b00};
        mem_wdata <= a_wdata;
        mem_be    <= a_be;
      end
      if (latch_rf) begin
        rf_data <= a_ldata;
        rf_addr <= rd_q;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit for the rv32i single-cycle core. Sits between the register file and the data-memory bus. Consumes the rs1/rs2 operands read from the register file and the decoded immediate. Performs one aligned byte/half/word access over a req/ack bus. For loads, produces the extended result and a write strobe that feeds the register file's write port.

## Interface
- `WIDTH`, 32: data/address width; only 32 is supported, since byte enables are fixed at 4 lanes.
- `AW`, 5: register-index width (`rd`, `rf_addr`).
- `TIMEOUT`, 255: max cycles `mem_req` may wait for `mem_ack`; 0 disables the timeout.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  operation valid; sampled only in IDLE.
- `is_store`  in  1  1 = store, 0 = load.
- `funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; stores accept 000/001/010 only.
- `base`  in  WIDTH  rs1 value.
- `offset`  in  WIDTH  sign-extended immediate.
- `store_data`  in  WIDTH  rs2 value.
- `rd`  in  AW  load destination register.
- `busy`  out  1  high from the cycle after accept through the `done` cycle.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  high with `done` on a misaligned access, illegal funct3, or timeout.
- `mem_req`  out  1  bus request; held until ack.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  WIDTH  word-aligned address: `{ea[31:2],2'b00}`.
- `mem_wdata`  out  WIDTH  store data replicated into lanes.
- `mem_be`  out  4  byte enables.
- `mem_ack`  in  1  completion; read data valid in the same cycle.
- `mem_rdata`  in  WIDTH  read word.
- `rf_we`  out  1  register-file write strobe (rising-edge consumer).
- `rf_addr`  out  AW  write index.
- `rf_data`  out  WIDTH  write data.

## Operation
- Effective address `ea = base + offset`, computed modulo 2^32.
- **States:** IDLE, REQ, WB_SETUP, WB, FIN.
- **IDLE, `start=1`:** latch all inputs and compute `ea`.
  - If funct3 is illegal, or `ea` is misaligned (H with `ea[0]`, W with `ea[1:0]≠0`) → FIN with fault; no bus access.
  - Otherwise → REQ.
- **REQ:** `mem_req=1`; address/data/byte enables stable. On `mem_ack`:
  - store → FIN;
  - load → latch the extracted data into `rf_data` and `rd` into `rf_addr`, then → WB_SETUP.
- **Load extraction:** select the byte or halfword at `ea[1:0]`; sign-extend for B/H, zero-extend for BU/HU; W passes through.
- **Store lanes:**
  - B: `mem_be = 0001<<ea[1:0]`, wdata = byte ×4.
  - H: `mem_be = 0011<<ea[1:0]`, wdata = half ×2.
  - W: `mem_be = 1111`.
- **WB_SETUP:** `rf_addr`/`rf_data` stable, `rf_we=0` (setup cycle for the edge-triggered write) → WB.
- **WB:** `rf_we=1` unless `rd==0`; `done=1` → IDLE.
- **FIN:** `done=1`, `fault` as determined → IDLE.
- **Timeout:** a counter increments each REQ cycle without ack. When it reaches TIMEOUT → FIN with fault; `mem_req` drops and any later ack is ignored.
- `start` while busy is ignored; no queueing.

## Timing
- All outputs are registered.
- **Reset values:** all outputs 0, state IDLE, timeout counter 0.
- **Accept:** `start` sampled at edge E0; `mem_req` goes high in cycle E0+1.
- **Ack:** `mem_ack` high at edge Ek.
  - Store: `done` in cycle Ek+1.
  - Load: `rf_data` valid in cycle Ek+1; `rf_we` and `done` in cycle Ek+2.
- Minimum latency with zero-wait ack in the first REQ cycle: store 2 cycles; load 3 cycles from accept to `done`.
- Fault on misalign/illegal: `done`+`fault` in cycle E0+1; `mem_req` never asserts.
- `rf_addr`/`rf_data` hold their last values through IDLE. `rf_we` deasserts in the cycle after WB.
- `mem_req` deasserts in the cycle after ack or timeout. `mem_ack` is don't-care outside REQ.
- **Reset mid-operation:** outputs clear immediately (asynchronous), including `mem_req` and `rf_we`. The transaction is abandoned and no write-back occurs.
- `start` in the `done` cycle is ignored; the next accept is possible one cycle later.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (`F3_B/H/W/BU/HU`);
  - state enum `lsu_state_t`;
  - `ea`/byte-enable width constants.
- Sub-module `lsu_align`: combinational load extraction plus store lane/byte-enable generation, shared by the REQ and latch paths. The FSM, timeout counter, and output registers stay in the top.

## Test plan
- **LW, 0-wait:** `base=0x100`, `offset=4`, `rd=5`; ack in the first REQ cycle with `rdata=0xDEADBEEF` → `mem_addr=0x104`, `mem_be=1111`; `rf_we` pulses with `rf_addr=5`, `rf_data=0xDEADBEEF`; `done` 3 cycles after accept.
- **LB vs LBU:** `ea=0x203`, `rdata=0x80FF_0000` → LB gives `rf_data=0xFFFFFF80`; LBU gives `0x00000080`.
- **SH at `ea=0x302`, `store_data=0x1234ABCD`:** `mem_addr=0x300`, `mem_be=1100`, `mem_wdata=0xABCDABCD`, `mem_we=1`; ack after 3 wait cycles → `done` the next cycle; `rf_we` never rises.
- **Misaligned/illegal:**
  - LW with `ea=0x102` → `done`+`fault` at E0+1, no `mem_req`.
  - `funct3=011` → same result.
  - LW with `rd=0` → `done` with `rf_we=0`.
- **Timeout:** `TIMEOUT=4`, ack never asserted → `mem_req` high for 4 cycles, then `done`+`fault`; a late ack produces no output change.
- **Reset mid-REQ:**
  - Assert `rst` between edges → `mem_req`, `busy`, `rf_we` go 0 immediately.
  - After release, a new LW completes normally.
  - A `start` pulse during `busy` is ignored.
